// File: rtl/key_defs_pkg.sv
// Shared definitions for the key debounce filter: FSM encodings and count limits.
// CNT_MAX_50MHZ gives a 20 ms qualify window at 50 MHz; CNT_MAX_SIM keeps simulations short.
package key_defs;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FILTER_DN = 2'd1,
        ST_DOWN      = 2'd2,
        ST_FILTER_UP = 2'd3
    } key_fsm_e;

    localparam int CNT_MAX_50MHZ = 999_999;
    localparam int CNT_MAX_SIM   = 15;

    // Edge of a sampled level given the previous and current sample.
    function automatic logic edge_fall(input logic prev, input logic cur);
        return prev & ~cur;
    endfunction

    function automatic logic edge_rise(input logic prev, input logic cur);
        return ~prev & cur;
    endfunction

endpackage

// File: rtl/key_filter_sync_2ff.sv
// Two-flop synchroniser for asynchronous pin inputs, with a configurable reset level
// so that idle-high and idle-low pins both come out of reset without a spurious edge.
module sync_2ff #(
    parameter int   WIDTH   = 1,
    parameter logic RST_VAL = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_s0;
    logic [WIDTH-1:0] r_s1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s0 <= {WIDTH{RST_VAL}};
            r_s1 <= {WIDTH{RST_VAL}};
        end else begin
            r_s0 <= i_d;
            r_s1 <= r_s0;
        end
    end

    assign o_q = r_s1;

endmodule

// File: rtl/key_filter.sv
// Debounces one active-low push-button: a press or release is confirmed only after the
// synchronised level stays put for CNT_MAX+1 cycles; emits a level and a one-cycle flag.
module key_filter
    import key_defs::*;
#(
    parameter int CNT_MAX = CNT_MAX_50MHZ,
    parameter int CNT_W   = 20
) (
    input  logic clk_50mhz,
    input  logic rst,
    input  logic key_in,
    output logic key_flag,
    output logic key_state
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             w_s1;
    logic             w_fall;
    logic             w_rise;
    logic             r_s2;
    key_fsm_e         r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_flag;
    logic             r_level;

    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_sync (
        .i_clk (clk_50mhz),
        .i_rst (rst),
        .i_d   (key_in),
        .o_q   (w_s1)
    );

    assign w_fall = edge_fall(r_s2, w_s1);
    assign w_rise = edge_rise(r_s2, w_s1);

    // An opposite edge while filtering always wins over reaching the terminal count.
    always_ff @(posedge clk_50mhz) begin
        if (rst) begin
            r_s2    <= 1'b1;
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_flag  <= 1'b0;
            r_level <= 1'b1;
        end else begin
            r_s2   <= w_s1;
            r_flag <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_fall) begin
                        r_state <= ST_FILTER_DN;
                    end
                end
                ST_FILTER_DN: begin
                    if (w_rise) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= ST_DOWN;
                        r_cnt   <= '0;
                        r_flag  <= 1'b1;
                        r_level <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                ST_DOWN: begin
                    r_cnt <= '0;
                    if (w_rise) begin
                        r_state <= ST_FILTER_UP;
                    end
                end
                ST_FILTER_UP: begin
                    if (w_fall) begin
                        r_state <= ST_DOWN;
                        r_cnt   <= '0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                        r_flag  <= 1'b1;
                        r_level <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign key_flag  = r_flag;
    assign key_state = r_level;

endmodule
